// File: rtl/bp_nonsynth_host_master.sv
// Test-side host I/O initiator: turns putchar / getchar / finish requests into
// uncached memory commands, waits for the matching response, checks it, and
// returns getchar data. Only one transaction is outstanding at a time.
// Processor configuration is given as discrete parameters and the memory
// message layout is defined locally, MSB to LSB:
//   {data, payload, size, addr, msg_type}
module bp_nonsynth_host_master
  #(parameter int unsigned paddr_width_p        = 40
  , parameter int unsigned cce_block_width_p    = 64
  , parameter int unsigned lce_id_width_p       = 4
  , parameter int unsigned lce_assoc_p          = 8
  , parameter int unsigned num_core_p           = 4
  , parameter logic [63:0] putchar_addr_p       = 64'h0010_1000
  , parameter logic [63:0] getchar_addr_p       = 64'h0010_0000
  , parameter logic [63:0] finish_addr_p        = 64'h0010_2000
  , parameter int unsigned timeout_p            = 1024
  , localparam int unsigned core_width_lp        = (num_core_p > 1) ? $clog2(num_core_p) : 1
  , localparam int unsigned payload_width_lp     = lce_id_width_p + $clog2(lce_assoc_p)
  , localparam int unsigned cce_mem_msg_width_lp = cce_block_width_p + payload_width_lp + 3
                                                   + paddr_width_p + 4
  )
  (input  logic                            clk_i
  , input  logic                            reset_i

  , output logic [cce_mem_msg_width_lp-1:0] io_cmd_o
  , output logic                            io_cmd_v_o
  , input  logic                            io_cmd_yumi_i

  , input  logic [cce_mem_msg_width_lp-1:0] io_resp_i
  , input  logic                            io_resp_v_i
  , output logic                            io_resp_ready_o

  , input  logic [7:0]                      putchar_data_i
  , input  logic                            putchar_v_i
  , output logic                            putchar_ready_o

  , input  logic                            getchar_v_i
  , output logic                            getchar_ready_o
  , output logic [7:0]                      getchar_data_o
  , output logic                            getchar_data_v_o

  , input  logic                            finish_v_i
  , input  logic [core_width_lp-1:0]        finish_core_i
  , input  logic                            finish_fail_i
  , output logic                            finish_ready_o

  , output logic                            busy_o
  , output logic                            error_o
  );

  localparam logic [3:0] uc_rd_lp  = 4'd2;
  localparam logic [3:0] uc_wr_lp  = 4'd3;
  localparam logic [2:0] size_8_lp = 3'b011;

  localparam int unsigned cnt_width_lp = $clog2(timeout_p + 1);
  localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(timeout_p - 1);

  typedef struct packed {
    logic [cce_block_width_p-1:0] data;
    logic [payload_width_lp-1:0]  payload;
    logic [2:0]                   size;
    logic [paddr_width_p-1:0]     addr;
    logic [3:0]                   msg_type;
  } msg_s;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;

  state_e state, state_n;
  msg_s   cmd_r, cmd_n, resp;
  logic   get_r, get_n;
  logic   load;
  logic   timeout;
  logic   mismatch;
  logic   set_error;
  logic [cnt_width_lp-1:0] cnt;
  logic [63:0] fin_addr;

  // Only the header fields and the low data byte of a response are inspected.
  logic unused_resp_bits;

  assign resp     = msg_s'(io_resp_i);
  assign io_cmd_o = cmd_r;
  assign busy_o   = (state != IDLE);
  assign fin_addr = finish_addr_p | (64'(finish_core_i) << 3);
  assign mismatch = (resp.msg_type != cmd_r.msg_type) || (resp.addr != cmd_r.addr);
  assign unused_resp_bits = ^{resp.data[cce_block_width_p-1:8], resp.payload, resp.size};

  // Next state, handshakes and request-to-command encoding.
  always_comb begin
    state_n         = state;
    load            = 1'b0;
    cmd_n           = '0;
    get_n           = 1'b0;
    timeout         = 1'b0;
    finish_ready_o  = 1'b0;
    putchar_ready_o = 1'b0;
    getchar_ready_o = 1'b0;
    io_cmd_v_o      = 1'b0;
    io_resp_ready_o = 1'b0;
    cmd_n.size      = size_8_lp;
    case (state)
      IDLE: begin
        if (finish_v_i) begin
          finish_ready_o = 1'b1;
          load           = 1'b1;
          cmd_n.msg_type = uc_wr_lp;
          cmd_n.addr     = fin_addr[paddr_width_p-1:0];
          cmd_n.data[0]  = finish_fail_i;
          state_n        = SEND;
        end else if (putchar_v_i) begin
          putchar_ready_o  = 1'b1;
          load             = 1'b1;
          cmd_n.msg_type   = uc_wr_lp;
          cmd_n.addr       = putchar_addr_p[paddr_width_p-1:0];
          cmd_n.data[7:0]  = putchar_data_i;
          state_n          = SEND;
        end else if (getchar_v_i) begin
          getchar_ready_o = 1'b1;
          load            = 1'b1;
          get_n           = 1'b1;
          cmd_n.msg_type  = uc_rd_lp;
          cmd_n.addr      = getchar_addr_p[paddr_width_p-1:0];
          state_n         = SEND;
        end
      end
      SEND: begin
        io_cmd_v_o = 1'b1;
        if (io_cmd_yumi_i) state_n = WAIT;
      end
      WAIT: begin
        io_resp_ready_o = 1'b1;
        if (io_resp_v_i) begin
          state_n = IDLE;
        end else if (cnt == cnt_last_lp) begin
          timeout = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign set_error = timeout
                   || ((state == WAIT) && io_resp_v_i && mismatch)
                   || ((state != WAIT) && io_resp_v_i);

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_n;
  end

  // Command register, held stable from accept until the response returns.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cmd_r <= '0;
      get_r <= 1'b0;
    end else if (load) begin
      cmd_r <= cmd_n;
      get_r <= get_n;
    end
  end

  // Response timeout counter: cleared on command accept, saturating in WAIT.
  always_ff @(posedge clk_i) begin
    if (reset_i)                                cnt <= '0;
    else if ((state == SEND) && io_cmd_yumi_i) cnt <= '0;
    else if ((state == WAIT) && (cnt != '1))    cnt <= cnt + 1'b1;
  end

  // Sticky error flag.
  always_ff @(posedge clk_i) begin
    if (reset_i)        error_o <= 1'b0;
    else if (set_error) error_o <= 1'b1;
  end

  // Registered getchar return with a one-cycle valid pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      getchar_data_o   <= '0;
      getchar_data_v_o <= 1'b0;
    end else begin
      getchar_data_v_o <= (state == WAIT) && io_resp_v_i && get_r;
      if ((state == WAIT) && io_resp_v_i && get_r) getchar_data_o <= resp.data[7:0];
    end
  end

endmodule

// File: doc/bp_nonsynth_host_master.md
Name: bp_nonsynth_host_master

Overview:
- Nonsynthesizable test-side initiator for the host I/O memory-message interface: the core-side counterpart of the host responder.
- Converts simple user requests (putchar byte, getchar poll, finish with pass/fail) into bp_cce_mem_msg_s uncached commands on io_cmd.
- Consumes and checks the matching io_resp, returning getchar data to the requester.
- Used in unit benches and by testbench-driven cores to exercise the host device without a full core.

Parameters:
- bp_params_p, e_bp_inv_cfg, processor config; supplies paddr_width_p, cce_block_width_p, lce_id_width_p, lce_assoc_p, num_core_p.
- putchar_addr_p, 64'h0010_1000, putchar device address.
- getchar_addr_p, 64'h0010_0000, getchar device address.
- finish_addr_p, 64'h0010_2000, finish base address; core index is placed at addr[3+:lg(num_core_p)].
- timeout_p, 1024, cycles to wait for a response before flagging an error.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- io_cmd_o  out  cce_mem_msg_width_lp  command message.
- io_cmd_v_o  out  1  command valid.
- io_cmd_yumi_i  in  1  responder accepted the command.
- io_resp_i  in  cce_mem_msg_width_lp  response message.
- io_resp_v_i  in  1  response valid.
- io_resp_ready_o  out  1  master can accept a response.
- putchar_data_i  in  8  byte to print.
- putchar_v_i  in  1  putchar request valid.
- putchar_ready_o  out  1  putchar request accepted this cycle.
- getchar_v_i  in  1  getchar request valid.
- getchar_ready_o  out  1  getchar request accepted this cycle.
- getchar_data_o  out  8  returned byte, data[7:0] of the response.
- getchar_data_v_o  out  1  one-cycle pulse when getchar_data_o is valid.
- finish_v_i  in  1  finish request valid.
- finish_core_i  in  lg(num_core_p)  core index to report.
- finish_fail_i  in  1  1 = FAIL, 0 = PASS; sent as data[0].
- finish_ready_o  out  1  finish request accepted this cycle.
- busy_o  out  1  FSM not in IDLE.
- error_o  out  1  sticky error flag.

Behaviour:
- FSM states: IDLE, SEND, WAIT. Reset puts the FSM in IDLE; clears error_o, io_cmd_v_o, getchar_data_v_o and all *_ready_o; drops any in-flight transaction.
- **IDLE:**
  - Arbitration priority is finish > putchar > getchar.
  - Exactly one *_ready_o is asserted, combinationally, for the highest-priority valid request.
  - The accepted request is latched into a command register. Next state is SEND.
  - With no valid requests, stay in IDLE.
- **Command encoding:**
  - putchar: uncached write, addr = putchar_addr_p, size 8 bytes, data = zero-extended byte.
  - getchar: uncached read, addr = getchar_addr_p, data = 0.
  - finish: uncached write, addr = finish_addr_p | (finish_core_i << 3), data = {63'b0, finish_fail_i}.
  - payload is 0 for all commands.
- **SEND:**
  - io_cmd_v_o = 1 and io_cmd_o is held stable until io_cmd_yumi_i.
  - On yumi, next state is WAIT and the timeout counter clears.
  - No timeout applies in SEND.
- **WAIT:**
  - io_resp_ready_o = 1.
  - On io_resp_v_i, the response is consumed in the same cycle and the FSM returns to IDLE.
  - A response with msg_type or addr differing from the issued command sets error_o.
  - For getchar, getchar_data_o is registered and getchar_data_v_o pulses the cycle after the response.
  - If the counter reaches timeout_p - 1 with no response: set error_o and return to IDLE.
- io_resp_ready_o = 0 outside WAIT. A response arriving outside WAIT is ignored (not consumed) and sets error_o.
- Only one transaction is outstanding at any time.
- Minimum latency is request accept to next accept = 3 cycles, with same-cycle yumi and next-cycle response.
- The timeout counter is width clog2(timeout_p + 1) and saturates; it does not wrap.
- error_o clears only on reset.

Test Plan:
- putchar_data_i = 8'h41, responder yumis immediately and responds the next cycle -> one io_cmd with addr 0x0010_1000, data 0x41, uncached write; busy_o low again after 3 cycles; error_o = 0.
- getchar request; responder returns data 64'h5A -> io_cmd is an uncached read to 0x0010_0000; getchar_data_v_o pulses once with getchar_data_o = 8'h5A.
- finish_v_i, putchar_v_i and getchar_v_i all asserted in the same cycle, finish_core_i = 1, finish_fail_i = 1:
  - only finish_ready_o is asserted, with cmd addr 0x0010_2008 and data[0] = 1;
  - putchar is then served, then getchar, in order.
- io_cmd_yumi_i held low for 20 cycles -> io_cmd_v_o stays high with io_cmd_o unchanged; no error.
- No response after yumi -> error_o rises exactly timeout_p cycles after yumi; FSM returns to IDLE; next request is accepted.
- Response with a mismatched addr -> error_o set. Reset asserted while in WAIT -> next cycle IDLE, error_o = 0, io_cmd_v_o = 0.
